// File: rtl/loader_pkg.sv
// Shared definitions for the UART memory loader: FSM states, framing constants
// and the checksum arithmetic used by the loader core.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_COUNT,
      ST_DATA,
      ST_CSUM
   } state_e;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         CSUM_W    = 8;

   // Modulo-256 running sum of frame bytes.
   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [7:0]        b);
      return acc + b;
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Reloadable inter-byte timeout: while run is high, counts cycles without a
// kick and flags expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic kick,
   output logic expired
);

   localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload whenever stopped or kicked; otherwise count one idle cycle down.
   always_comb begin
      cnt_d   = RELOAD;
      expired = 1'b0;
      if (run && !kick) begin
         cnt_d   = cnt_q - ONE;
         expired = (cnt_q == ONE);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_mem_loader.sv
// Framed UART byte loader: parses SYNC/ADDR/COUNT/DATA/CSUM frames, packs
// little-endian 32-bit words, writes them to consecutive memory addresses and
// reports checksum/timeout status.
module uart_mem_loader
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 6,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [CSUM_W-1:0]       sum_q, sum_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    expired;

   loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (state_q != ST_IDLE),
      .kick   (rx_valid),
      .expired(expired)
   );

   // Frame parser: next state, word assembly, checksum and status updates.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      byte_idx_d  = byte_idx_q;
      sum_d       = sum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      error_d     = error_q;

      if (expired) begin
         state_d = ST_IDLE;
         error_d = 1'b1;
      end else if (rx_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d    = ST_ADDR;
                  done_d     = 1'b0;
                  error_d    = 1'b0;
                  sum_d      = '0;
                  byte_idx_d = '0;
               end
            end
            ST_ADDR: begin
               addr_d  = rx_data[ADDR_WIDTH-1:0];
               sum_d   = csum_add(sum_q, rx_data);
               state_d = ST_COUNT;
            end
            ST_COUNT: begin
               cnt_d   = rx_data;
               sum_d   = csum_add(sum_q, rx_data);
               state_d = (rx_data == 8'd0) ? ST_CSUM : ST_DATA;
            end
            ST_DATA: begin
               mem_wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               sum_d      = csum_add(sum_q, rx_data);
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  // Last lane completes the word: write it now, before the checksum is known.
                  mem_we_d   = 1'b1;
                  mem_addr_d = addr_q;
                  addr_d     = addr_q + ADDR_WIDTH'(1);
                  cnt_d      = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               done_d  = (rx_data == sum_q);
               error_d = (rx_data != sum_q);
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops everything, including any pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         byte_idx_q  <= '0;
         sum_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         byte_idx_q  <= byte_idx_d;
         sum_q       <= sum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: frame-level model predicts the write stream and
// status levels; a per-cycle compare process checks the DUT against it.
module tb_uart_mem_loader;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic          error;

   uart_mem_loader #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int               vectors    = 0;
   int               miscompares = 0;
   logic             exp_busy   = 1'b0;
   logic             exp_done   = 1'b0;
   logic             exp_error  = 1'b0;
   logic [AW+DW-1:0] exp_q[$];
   logic [AW-1:0]    log_q[$];
   logic [AW-1:0]    last_addr  = '0;
   logic [DW-1:0]    last_data  = '0;
   logic [31:0]      wbuf[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Frame checksum from the byte-level definition: ADDR + COUNT + every data byte, mod 256.
   function automatic logic [7:0] frame_sum(input logic [7:0] a, input int n);
      int s;
      s = int'(a) + n;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 4; b++)
            s += int'((wbuf[i] >> (8 * b)) & 32'hFF);
      return 8'(s);
   endfunction

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends a whole frame; expected writes are queued as each word's last byte goes out.
   task automatic send_frame(input logic [7:0] a, input int n, input logic [7:0] adj, input int gap);
      logic [AW-1:0] wa;
      logic [7:0]    cs;
      cs = frame_sum(a, n) + adj;
      wa = a[AW-1:0];
      send(8'hA5);
      exp_busy  = 1'b1;
      exp_done  = 1'b0;
      exp_error = 1'b0;
      idle(gap);
      send(a);
      idle(gap);
      send(8'(n));
      idle(gap);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) begin
            send(wbuf[i][8*b +: 8]);
            if (b == 3) begin
               exp_q.push_back({wa, wbuf[i]});
               wa = wa + 1'b1;
            end
            idle(gap);
         end
      end
      send(cs);
      exp_busy  = 1'b0;
      exp_done  = (adj == 8'h00);
      exp_error = (adj != 8'h00);
   endtask

   // Per-cycle check of status levels and of every write against the predicted stream.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         chk("error", 64'(error), 64'(exp_error));
         if (mem_we) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write at %0t",
                        mem_addr, mem_wdata, $time);
            end else begin
               logic [AW+DW-1:0] e;
               e = exp_q.pop_front();
               chk("write_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
               chk("write_data", 64'(mem_wdata), 64'(e[DW-1:0]));
            end
            log_q.push_back(mem_addr);
            last_addr = mem_addr;
            last_data = mem_wdata;
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      chk("reset_mem_we", 64'(mem_we), 64'd0);
      chk("reset_mem_addr", 64'(mem_addr), 64'd0);
      chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_error", 64'(error), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Good frame with a one-cycle gap between bytes.
      wbuf[0] = 32'h1234_5678;
      chk("model_csum_good", 64'(frame_sum(8'h04, 1)), 64'h19);
      send_frame(8'h04, 1, 8'h00, 1);
      idle(2);
      chk("good_addr", 64'(last_addr), 64'h04);
      chk("good_data", 64'(last_data), 64'h1234_5678);
      chk("good_done", 64'(done), 64'd1);

      // Address wrap 0x3F -> 0x00.
      wbuf[0] = 32'h1111_1111;
      wbuf[1] = 32'h2222_2222;
      log_q.delete();
      send_frame(8'h3F, 2, 8'h00, 0);
      idle(2);
      chk("wrap_count", 64'(log_q.size()), 64'd2);
      if (log_q.size() == 2) begin
         chk("wrap_first", 64'(log_q[0]), 64'h3F);
         chk("wrap_second", 64'(log_q[1]), 64'h00);
      end

      // Bad checksum: write still happens, error reported.
      wbuf[0] = 32'h1234_5678;
      chk("model_csum_bad", 64'(8'(frame_sum(8'h04, 1) + 8'hFF)), 64'h18);
      send_frame(8'h04, 1, 8'hFF, 0);
      idle(2);
      chk("bad_error", 64'(error), 64'd1);
      chk("bad_done", 64'(done), 64'd0);
      chk("bad_data", 64'(last_data), 64'h1234_5678);

      // Timeout after exactly TO idle cycles, no write.
      send(8'hA5);
      exp_busy  = 1'b1;
      exp_done  = 1'b0;
      exp_error = 1'b0;
      send(8'h04);
      idle(TO - 1);
      chk("timeout_still_busy", 64'(busy), 64'd1);
      idle(1);
      exp_busy  = 1'b0;
      exp_error = 1'b1;
      chk("timeout_busy", 64'(busy), 64'd0);
      chk("timeout_error", 64'(error), 64'd1);
      idle(3);

      // Noise then back-to-back good frame.
      send(8'h00);
      send(8'hFF);
      wbuf[0] = 32'h1234_5678;
      send_frame(8'h04, 1, 8'h00, 0);
      idle(2);
      chk("b2b_data", 64'(last_data), 64'h1234_5678);

      // Mid-frame 0xA5 is data; upper address bits ignored (0xC7 -> 0x07).
      wbuf[0] = 32'hA5A5_A5A5;
      wbuf[1] = 32'h00A5_0102;
      send_frame(8'hC7, 2, 8'h00, 0);
      idle(2);
      chk("a5_addr", 64'(last_addr), 64'h08);
      chk("a5_data", 64'(last_data), 64'h00A5_0102);

      // Zero-length frame: A5 10 00 10.
      send_frame(8'h10, 0, 8'h00, 0);
      idle(2);
      chk("n0_done", 64'(done), 64'd1);

      // Reset after two data bytes.
      send(8'hA5);
      exp_busy = 1'b1;
      exp_done = 1'b0;
      exp_error = 1'b0;
      send(8'h04);
      send(8'h01);
      send(8'h78);
      send(8'h56);
      #2;
      rst_n = 1'b0;
      #1;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_error = 1'b0;
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      #3;
      rst_n = 1'b1;
      idle(2);
      wbuf[0] = 32'hCAFE_F00D;
      send_frame(8'h21, 1, 8'h00, 0);
      idle(2);
      chk("post_rst_addr", 64'(last_addr), 64'h21);
      chk("post_rst_data", 64'(last_data), 64'hCAFE_F00D);

      idle(2);
      chk("pending_writes", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Byte-stream loader that sits directly upstream of the data memory write port. It takes framed bytes from the UART receiver and assembles them into little-endian 32-bit words. It writes those words into consecutive data-memory addresses and checks an 8-bit frame checksum. The core is held via `busy` while a frame is in flight.

## Interface
Parameters:
- `DATA_WIDTH`, 32: memory word width; fixed at 32 (4 bytes per word).
- `ADDR_WIDTH`, 6: memory word-address width; matches the data memory.
- `TIMEOUT_CYCLES`, 50000: idle cycles between bytes before a frame is aborted.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte; may be high on consecutive cycles.
- `rx_data`  in  8  received byte.
- `mem_we`  out  1  one-cycle write strobe to the data memory.
- `mem_addr`  out  ADDR_WIDTH  word address for the write.
- `mem_wdata`  out  DATA_WIDTH  assembled word.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  level: the last frame completed with a good checksum.
- `error`  out  1  level: the last frame failed on checksum or timeout.

## Operation
- Frame format: SYNC byte 0xA5, ADDR byte, COUNT byte N, 4·N data bytes (LSB first per word), CSUM byte.
- Only `ADDR[ADDR_WIDTH-1:0]` is used; upper bits are ignored.
- CSUM is the modulo-256 sum of every byte after SYNC: ADDR, COUNT and all data bytes.
- States and transitions:
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 goes to ADDR and clears `done`, `error`, the checksum accumulator and the byte counter.
  - ADDR: latch the start address, add the byte to the sum, go to COUNT.
  - COUNT: latch N and add it to the sum. N=0 goes directly to CSUM; otherwise go to DATA.
  - DATA: shift each byte into the word register at lane `byte_idx` (0..3) and add it to the sum.
    - On lane 3, issue the write and increment the address.
    - Decrement the remaining-word count; when it reaches 0, go to CSUM.
  - CSUM: if the byte equals the sum, set `done`; otherwise set `error`. Return to IDLE.
- Address wrap-around: the address increments modulo 2^ADDR_WIDTH (0x3F+1 → 0x00).
- Writes are not deferred until the checksum is checked. A bad frame leaves its words in memory, and `error` reports that.
- Timeout: in any non-IDLE state, a counter counts cycles without `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`, set `error` and go to IDLE.
  - The counter reloads on every accepted byte.
- A 0xA5 byte received mid-frame is treated as data, not as a resync.

## Timing
- All outputs are registered. Reset values: state IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, all counters 0.
- `mem_we` is high for exactly one cycle: the cycle after the `rx_valid` edge of a word's 4th byte. `mem_addr`/`mem_wdata` are valid in that same cycle.
- `busy` rises the cycle after SYNC is accepted. It falls the cycle after CSUM is accepted or the timeout fires.
- `done`/`error` update in the same cycle `busy` falls, and hold until the next SYNC.
- Full-rate input must be handled: `rx_valid` on every cycle, with no byte dropped.
- Reset asserted mid-frame clears everything immediately (asynchronously). No partial write is issued after reset.

## Structure
- Shared package `loader_pkg` holds:
  - the state encoding (IDLE, ADDR, COUNT, DATA, CSUM);
  - `SYNC_BYTE` = 8'hA5;
  - the checksum width (8).
- One sub-module: `loader_timeout`, a reloadable down-counter (inputs `clk`, `rst_n`, `run`, `kick`; output `expired`).
- The FSM, word assembler and checksum stay in the top module.

## Test plan
- Good frame: A5 04 01 78 56 34 12, CSUM 19 → one `mem_we` with addr 0x04, data 0x12345678; then `done`=1, `error`=0, `busy`=0.
- Wrap: A5 3F 02, words 0x11111111 and 0x22222222, correct CSUM → writes at 0x3F then 0x00, in that order; `done`=1.
- Bad checksum: the good frame above with CSUM 0x18 → the write still occurs; `error`=1, `done`=0.
- Timeout: A5 04, then silence for `TIMEOUT_CYCLES` (bench may set it to 16) → `error`=1 and IDLE after exactly 16 idle cycles; no `mem_we`.
- Noise and back-to-back bytes: 00 FF, then a good frame with `rx_valid` high every cycle → the leading bytes are ignored; the write is correct; `mem_we` is a single-cycle pulse.
- Reset mid-frame: drop `rst_n` after 2 data bytes → all outputs 0 at once; a following good frame loads correctly.
